spi_cmd_tx: RTL and testbench

Master-side SPI command transmitter: the sending end of the FPGA's configuration SPI link. It turns one accepted 4-bit command plus 8-bit payload into a 16-bit frame on `ncs`/`spck`/`mosi`, sent MSB first. A receiver that shifts `mosi` on `spck` rising edges while `ncs` is low, and decodes `[15:12]` on `ncs` rising, sees exactly that word. The block is used for relay setups where one board configures another FPGA, and as the stimulus driver in SPI benches. It also captures `miso` for readback.

---
 rtl/spi_cmd_tx_if.sv | 25 ++
 rtl/spi_cmd_tx.sv | 134 +++++++++++++
 tb/tb_spi_cmd_tx.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_tx_if.sv
// Command/readback bundle between a command source and spi_cmd_tx, plus the SPI pins.
// master = the transmitter block, slave = the command source / SPI far end.
interface spi_cmd_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd;
  logic [7:0]  data;
  logic        ncs;
  logic        spck;
  logic        mosi;
  logic        miso;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;

  modport master (
    input  cmd_valid, cmd, data, miso,
    output cmd_ready, ncs, spck, mosi, rx_data, rx_valid, busy
  );

  modport slave (
    output cmd_valid, cmd, data, miso,
    input  cmd_ready, ncs, spck, mosi, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_cmd_tx.sv
// SPI master command transmitter: one {cmd,0000,data} frame per accept, MSB first, miso captured.
// ncs low 33*CLK_DIV clocks per frame then GAP_CYCLES high before next accept; cmd_ready only in IDLE.
module spi_cmd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic         ck_1356meg,
  input  logic         reset,
  spi_cmd_tx_if.master bus
);
  localparam int PH_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] PH_D_LAST = PH_W'(CLK_DIV - 1);
  // GAP is one clock short of GAP_CYCLES: the IDLE clock before the next accept also keeps ncs high.
  localparam logic [PH_W-1:0] PH_G_LAST = PH_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

  state_t          r_state;
  logic [PH_W-1:0] r_phase;
  logic [3:0]      r_bit;
  logic [14:0]     r_tx_sr;
  logic [15:0]     r_rx_sr;
  logic [15:0]     r_rx_data;
  logic            r_ncs;
  logic            r_spck;
  logic            r_mosi;
  logic            r_rx_valid;
  logic            r_busy;
  logic            w_accept;
  logic            w_d_end;

  assign bus.cmd_ready = (r_state == S_IDLE) & ~reset;
  assign w_accept      = bus.cmd_valid & bus.cmd_ready;
  assign w_d_end       = (r_phase == PH_D_LAST);

  assign bus.ncs      = r_ncs;
  assign bus.spck     = r_spck;
  assign bus.mosi     = r_mosi;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = r_busy;

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bit      <= 4'd0;
      r_tx_sr    <= 15'd0;
      r_rx_sr    <= 16'd0;
      r_rx_data  <= 16'd0;
      r_ncs      <= 1'b1;
      r_spck     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Bit 15 goes straight to mosi; the remaining 15 bits wait in the shifter.
            r_mosi  <= bus.cmd[3];
            r_tx_sr <= {bus.cmd[2:0], 4'b0000, bus.data};
            r_rx_sr <= 16'd0;
            r_ncs   <= 1'b0;
            r_busy  <= 1'b1;
            r_phase <= '0;
            r_bit   <= 4'd0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP, S_LOW: begin
          if (w_d_end) begin
            r_phase <= '0;
            r_spck  <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_HIGH: begin
          if (w_d_end) begin
            r_phase <= '0;
            r_spck  <= 1'b0;
            r_rx_sr <= {r_rx_sr[14:0], bus.miso};
            r_bit   <= r_bit + 4'd1;
            if (r_bit == 4'd15) begin
              r_state <= S_HOLD;
            end else begin
              r_mosi  <= r_tx_sr[14];
              r_tx_sr <= {r_tx_sr[13:0], 1'b0};
              r_state <= S_LOW;
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_HOLD: begin
          if (w_d_end) begin
            r_phase    <= '0;
            r_ncs      <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_data  <= r_rx_sr;
            r_rx_valid <= 1'b1;
            if (GAP_CYCLES > 1) begin
              r_state <= S_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_GAP: begin
          if (r_phase == PH_G_LAST) begin
            r_phase <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ncs   <= 1'b1;
          r_spck  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_tx.sv
// Bench for spi_cmd_tx: a D=4/GAP=8 instance and a D=1/GAP=3 instance, each watched by a
// behavioural SPI receiver/slave model that rebuilds frames from the pins.
`timescale 1ns/1ps
module tb_spi_cmd_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_cmd_tx_if ifa ();
  spi_cmd_tx_if ifb ();

  spi_cmd_tx #(.CLK_DIV(4), .GAP_CYCLES(8)) u_dut_a (.ck_1356meg(clk), .reset(reset), .bus(ifa.master));
  spi_cmd_tx #(.CLK_DIV(1), .GAP_CYCLES(3)) u_dut_b (.ck_1356meg(clk), .reset(reset), .bus(ifb.master));

  int n_checks = 0;
  int n_fail   = 0;

  logic        loop [2];
  logic        slave_miso [2];
  logic [15:0] sw [2];
  assign ifa.miso = loop[0] ? ifa.mosi : slave_miso[0];
  assign ifb.miso = loop[1] ? ifb.mosi : slave_miso[1];

  bit          mon_en = 1'b0;
  int          cyc = 0;
  logic        p_ncs [2];
  logic        p_spck [2];
  logic [15:0] sh [2];
  int          nb [2], low [2], sidx [2], fall_cyc [2], fall_gap [2];
  int          first_rise [2], last_rise [2], last_fall [2], min_per [2], max_per [2];
  int          viol [2], rxv_total [2], rxv_bad [2], frame_cnt [2];
  logic [15:0] f_word [2], f_rx [2];
  int          f_nb [2], f_low [2], f_lead [2], f_trail [2];
  logic        f_rxv [2];
  logic [7:0]  conf_word [2], divisor [2];
  logic        m_n, m_s, m_mo, m_rv;
  logic [15:0] m_rd;

  // Receiver shifts mosi on spck rise, decodes on ncs rise; slave drives miso MSB first,
  // advancing after each spck fall.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        m_n  = (c == 0) ? ifa.ncs      : ifb.ncs;
        m_s  = (c == 0) ? ifa.spck     : ifb.spck;
        m_mo = (c == 0) ? ifa.mosi     : ifb.mosi;
        m_rv = (c == 0) ? ifa.rx_valid : ifb.rx_valid;
        m_rd = (c == 0) ? ifa.rx_data  : ifb.rx_data;
        if (m_rv === 1'b1) begin
          rxv_total[c]++;
          if (!(p_ncs[c] === 1'b0 && m_n === 1'b1)) rxv_bad[c]++;
        end
        if (p_ncs[c] === 1'b1 && m_n === 1'b0) begin
          if (fall_cyc[c] >= 0) fall_gap[c] = cyc - fall_cyc[c];
          fall_cyc[c] = cyc; sh[c] = 16'd0; nb[c] = 0; low[c] = 0;
          first_rise[c] = -1; last_rise[c] = -1; min_per[c] = 1000; max_per[c] = 0;
          slave_miso[c] = sw[c][15]; sidx[c] = 14;
        end
        if (m_n === 1'b0) begin
          low[c]++;
          if (p_spck[c] === 1'b0 && m_s === 1'b1) begin
            sh[c] = {sh[c][14:0], m_mo};
            nb[c]++;
            if (first_rise[c] < 0) first_rise[c] = cyc;
            else begin
              if (cyc - last_rise[c] < min_per[c]) min_per[c] = cyc - last_rise[c];
              if (cyc - last_rise[c] > max_per[c]) max_per[c] = cyc - last_rise[c];
            end
            last_rise[c] = cyc;
          end
          if (p_spck[c] === 1'b1 && m_s === 1'b0) begin
            last_fall[c] = cyc;
            if (sidx[c] >= 0) begin slave_miso[c] = sw[c][sidx[c]]; sidx[c]--; end
          end
        end else if (p_ncs[c] === 1'b1 && m_s !== p_spck[c]) begin
          viol[c]++;
        end
        if (p_ncs[c] === 1'b0 && m_n === 1'b1) begin
          f_word[c] = sh[c]; f_nb[c] = nb[c]; f_low[c] = low[c]; f_rxv[c] = m_rv; f_rx[c] = m_rd;
          f_lead[c] = first_rise[c] - fall_cyc[c]; f_trail[c] = cyc - last_fall[c];
          frame_cnt[c]++;
          slave_miso[c] = 1'b0;
          if (nb[c] == 16) begin
            if (sh[c][15:12] == 4'b0001) conf_word[c] = sh[c][7:0];
            if (sh[c][15:12] == 4'b0010) divisor[c] = sh[c][7:0];
          end
        end
        p_ncs[c]  = m_n;
        p_spck[c] = m_s;
      end
    end
  end

  task automatic drive(input int c, input logic v, input logic [3:0] cm, input logic [7:0] d);
    if (c == 0) begin ifa.cmd_valid = v; ifa.cmd = cm; ifa.data = d; end
    else begin ifb.cmd_valid = v; ifb.cmd = cm; ifb.data = d; end
  endtask

  function automatic logic rdy(input int c);
    return (c == 0) ? ifa.cmd_ready : ifb.cmd_ready;
  endfunction

  task automatic wait_ready(input int c, output bit ok);
    int n = 0;
    while (rdy(c) !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    ok = (rdy(c) === 1'b1);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ready_timeout ch%0d: cmd_ready stayed %b, required 1", c, rdy(c)); end
  endtask

  // Offers a command, holds it until the accepting edge, then scrambles the inputs.
  task automatic send(input int c, input logic [3:0] cm, input logic [7:0] d);
    bit ok;
    @(negedge clk);
    drive(c, 1'b1, cm, d);
    wait_ready(c, ok);
    @(negedge clk);
    drive(c, 1'b0, 4'($urandom), 8'($urandom));
  endtask

  task automatic wait_frame(input int c, input int target);
    int n = 0;
    while (frame_cnt[c] < target && n < 5000) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (frame_cnt[c] < target) begin
      n_fail++; $display("FAIL frame_timeout ch%0d: frames %0d, required %0d", c, frame_cnt[c], target);
    end
  endtask

  task automatic test_reset();
    int fc;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (ifa.ncs !== 1'b1) begin n_fail++; $display("FAIL rst_ncs: got %b, required 1", ifa.ncs); end
    n_checks++; if (ifa.spck !== 1'b0) begin n_fail++; $display("FAIL rst_spck: got %b, required 0", ifa.spck); end
    n_checks++; if (ifa.mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b, required 0", ifa.mosi); end
    n_checks++; if (ifa.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", ifa.cmd_ready); end
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", ifa.busy); end
    n_checks++; if (ifa.rx_data !== 16'h0 || ifa.rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_rx: got %h/%b, required 0000/0", ifa.rx_data, ifa.rx_valid); end
    fc = frame_cnt[0];
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (ifa.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b, required 1", ifa.cmd_ready); end
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (frame_cnt[0] != fc || viol[0] != 0 || ifa.spck !== 1'b0) begin
      n_fail++; $display("FAIL rst_quiet: frames %0d viol %0d spck %b, required %0d 0 0", frame_cnt[0], viol[0], ifa.spck, fc); end
  endtask

  task automatic test_single_frame();
    int tgt = frame_cnt[0] + 1;
    loop[0] = 1'b0;
    sw[0] = 16'($urandom);
    send(0, 4'b0001, 8'hA5);
    wait_frame(0, tgt);
    n_checks++; if (f_word[0] !== 16'h10A5) begin n_fail++; $display("FAIL single_word: got %h, required 10a5", f_word[0]); end
    n_checks++; if (f_nb[0] != 16) begin n_fail++; $display("FAIL single_rises: got %0d, required 16", f_nb[0]); end
    n_checks++; if (f_low[0] != 132) begin n_fail++; $display("FAIL single_ncs_low: got %0d, required 132", f_low[0]); end
    n_checks++; if (f_lead[0] != 4 || f_trail[0] != 4) begin
      n_fail++; $display("FAIL single_lead_trail: got %0d/%0d, required 4/4", f_lead[0], f_trail[0]); end
    n_checks++; if (min_per[0] != 8 || max_per[0] != 8) begin
      n_fail++; $display("FAIL single_period: got %0d..%0d, required 8..8", min_per[0], max_per[0]); end
    n_checks++; if (conf_word[0] !== 8'hA5) begin n_fail++; $display("FAIL single_conf: got %h, required a5", conf_word[0]); end
    n_checks++; if (f_rx[0] !== sw[0] || f_rxv[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_rx: got %h/%b, required %h/1", f_rx[0], f_rxv[0], sw[0]); end
    n_checks++; if (ifa.cmd_ready !== 1'b0 || ifa.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_gap: ready/busy %b/%b, required 0/1", ifa.cmd_ready, ifa.busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int tgt = frame_cnt[0] + 2;
    @(negedge clk);
    drive(0, 1'b1, 4'b0001, 8'h3C);
    wait_ready(0, ok);
    @(negedge clk);
    drive(0, 1'b1, 4'b0010, 8'h5F);
    wait_ready(0, ok);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 8'h00);
    wait_frame(0, tgt);
    n_checks++; if (fall_gap[0] != 140) begin n_fail++; $display("FAIL b2b_period: got %0d, required 140", fall_gap[0]); end
    n_checks++; if (conf_word[0] !== 8'h3C || divisor[0] !== 8'h5F) begin
      n_fail++; $display("FAIL b2b_model: conf %h div %h, required 3c 5f", conf_word[0], divisor[0]); end
    n_checks++; if (f_word[0] !== 16'h205F) begin n_fail++; $display("FAIL b2b_word: got %h, required 205f", f_word[0]); end
  endtask

  task automatic test_loopback();
    int rv0 = rxv_total[0];
    int tgt = frame_cnt[0] + 1;
    loop[0] = 1'b1;
    send(0, 4'b0010, 8'hF0);
    wait_frame(0, tgt);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (f_rx[0] !== 16'h20F0 || ifa.rx_data !== 16'h20F0) begin
      n_fail++; $display("FAIL loop_rx: got %h/%h, required 20f0", f_rx[0], ifa.rx_data); end
    n_checks++; if (f_rxv[0] !== 1'b1 || rxv_total[0] - rv0 != 1 || rxv_bad[0] != 0) begin
      n_fail++; $display("FAIL loop_rxv: at_rise %b pulses %0d stray %0d, required 1 1 0", f_rxv[0], rxv_total[0] - rv0, rxv_bad[0]); end
    n_checks++; if (divisor[0] !== 8'hF0) begin n_fail++; $display("FAIL loop_div: got %h, required f0", divisor[0]); end
    loop[0] = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    int n = 0;
    int rv0 = rxv_total[0];
    int tgt = frame_cnt[0] + 1;
    sw[0] = 16'($urandom);
    @(negedge clk);
    drive(0, 1'b1, 4'b0001, 8'h77);
    wait_ready(0, ok);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 8'h00);
    do begin @(negedge clk); #1; n++; end while (nb[0] < 5 && n < 2000);
    n_checks++; if (nb[0] != 5) begin n_fail++; $display("FAIL abort_rises: got %0d, required 5", nb[0]); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (ifa.ncs !== 1'b1 || ifa.spck !== 1'b0 || ifa.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: ncs/spck/busy %b/%b/%b, required 1/0/0", ifa.ncs, ifa.spck, ifa.busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (frame_cnt[0] != tgt || f_nb[0] != 5) begin
      n_fail++; $display("FAIL abort_partial: frames %0d bits %0d, required %0d 5", frame_cnt[0], f_nb[0], tgt); end
    n_checks++; if (rxv_total[0] != rv0) begin n_fail++; $display("FAIL abort_rxv: got %0d pulses, required 0", rxv_total[0] - rv0); end
    send(0, 4'b0001, 8'h11);
    wait_frame(0, tgt + 1);
    n_checks++; if (f_word[0] !== 16'h1011 || f_nb[0] != 16 || conf_word[0] !== 8'h11) begin
      n_fail++; $display("FAIL abort_resend: word %h bits %0d conf %h, required 1011 16 11", f_word[0], f_nb[0], conf_word[0]); end
    n_checks++; if (f_rxv[0] !== 1'b1 || f_rx[0] !== sw[0] || viol[0] != 0) begin
      n_fail++; $display("FAIL abort_resend_rx: rx %h rxv %b viol %0d, required %h 1 0", f_rx[0], f_rxv[0], viol[0], sw[0]); end
  endtask

  task automatic test_random_frames(input int c, input int nfr, input int d);
    logic [3:0]  cm;
    logic [7:0]  dt;
    logic [15:0] exp_w, exp_rx;
    int tgt;
    for (int i = 0; i < nfr; i++) begin
      cm = 4'($urandom); dt = 8'($urandom);
      exp_w = {cm, 4'b0000, dt};
      loop[c] = 1'($urandom_range(0, 1));
      sw[c] = 16'($urandom);
      exp_rx = loop[c] ? exp_w : sw[c];
      tgt = frame_cnt[c] + 1;
      send(c, cm, dt);
      wait_frame(c, tgt);
      n_checks++; if (f_word[c] !== exp_w || f_nb[c] != 16) begin
        n_fail++; $display("FAIL rand_word ch%0d: got %h/%0d bits, required %h/16", c, f_word[c], f_nb[c], exp_w); end
      n_checks++; if (f_rx[c] !== exp_rx || f_rxv[c] !== 1'b1) begin
        n_fail++; $display("FAIL rand_rx ch%0d: got %h/%b, required %h/1", c, f_rx[c], f_rxv[c], exp_rx); end
      n_checks++; if (f_low[c] != 33 * d || min_per[c] != 2 * d || max_per[c] != 2 * d || f_lead[c] != d || f_trail[c] != d) begin
        n_fail++; $display("FAIL rand_timing ch%0d: low %0d per %0d..%0d lead %0d trail %0d, required %0d %0d %0d %0d",
                           c, f_low[c], min_per[c], max_per[c], f_lead[c], f_trail[c], 33 * d, 2 * d, d, d); end
    end
    loop[c] = 1'b0;
  endtask

  task automatic test_min_divider();
    bit ok;
    int tgt;
    test_random_frames(1, 4, 1);
    tgt = frame_cnt[1] + 2;
    @(negedge clk);
    drive(1, 1'b1, 4'b0001, 8'h42);
    wait_ready(1, ok);
    @(negedge clk);
    drive(1, 1'b1, 4'b0010, 8'h81);
    wait_ready(1, ok);
    @(negedge clk);
    drive(1, 1'b0, 4'h0, 8'h00);
    wait_frame(1, tgt);
    n_checks++; if (fall_gap[1] != 36) begin n_fail++; $display("FAIL min_b2b_period: got %0d, required 36", fall_gap[1]); end
    n_checks++; if (conf_word[1] !== 8'h42 || divisor[1] !== 8'h81 || viol[1] != 0) begin
      n_fail++; $display("FAIL min_model: conf %h div %h viol %0d, required 42 81 0", conf_word[1], divisor[1], viol[1]); end
  endtask

  initial begin
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      loop[c] = 1'b0; slave_miso[c] = 1'b0; sw[c] = 16'h0;
      p_ncs[c] = 1'b1; p_spck[c] = 1'b0; sh[c] = 16'h0;
      nb[c] = 0; low[c] = 0; sidx[c] = -1; fall_cyc[c] = -1; fall_gap[c] = 0;
      first_rise[c] = -1; last_rise[c] = -1; last_fall[c] = 0; min_per[c] = 0; max_per[c] = 0;
      viol[c] = 0; rxv_total[c] = 0; rxv_bad[c] = 0; frame_cnt[c] = 0;
      f_word[c] = 16'h0; f_rx[c] = 16'h0; f_nb[c] = 0; f_low[c] = 0; f_lead[c] = 0; f_trail[c] = 0;
      f_rxv[c] = 1'b0; conf_word[c] = 8'h0; divisor[c] = 8'h0;
    end
    drive(0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_loopback();
    test_abort();
    test_random_frames(0, 4, 4);
    test_min_divider();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
